// File: rtl/cart_mem_responder.sv
// Memory-side responder for the cartridge ROM/BSRAM strobe interface.
// Converts active-low strobes into single-outstanding req/ack transactions
// on a 16-bit backing memory, with one-word read latches for ROM and BSRAM
// and a one-deep, last-write-wins BSRAM write buffer.
module cart_mem_responder #(
    parameter logic [24:0] BSRAM_BASE = 25'h1000000
) (
    input  logic        MCLK,
    input  logic        RESET_N,

    input  logic [23:0] rom_addr,
    input  logic        rom_ce_n,
    input  logic        rom_oe_n,
    input  logic        rom_word,
    output logic [15:0] rom_q,

    input  logic [19:0] bsram_addr,
    input  logic [7:0]  bsram_d,
    input  logic        bsram_ce_n,
    input  logic        bsram_oe_n,
    input  logic        bsram_we_n,
    output logic [7:0]  bsram_q,

    output logic        mem_req,
    output logic        mem_we,
    output logic [24:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROM_RD = 2'd1,
        BS_RD  = 2'd2,
        BS_WR  = 2'd3
    } state_t;

    state_t      state_q, state_d;

    logic [15:0] rom_lat_q, rom_lat_d;
    logic [23:1] rom_tag_q, rom_tag_d;
    logic        rom_vld_q, rom_vld_d;

    logic [15:0] bs_lat_q, bs_lat_d;
    logic [19:1] bs_tag_q, bs_tag_d;
    logic        bs_vld_q, bs_vld_d;

    logic        we_dly_q, we_dly_d;
    logic        wr_pend_q, wr_pend_d;
    logic [19:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;

    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [24:0] mem_addr_q, mem_addr_d;
    logic [1:0]  mem_be_q, mem_be_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;

    logic        rom_miss;
    logic        bs_miss;
    logic        wr_edge;
    logic [19:1] bs_issued_tag;

    assign rom_miss = !rom_ce_n && !rom_oe_n && !(rom_vld_q && (rom_tag_q == rom_addr[23:1]));
    assign bs_miss  = !bsram_ce_n && !bsram_oe_n && !(bs_vld_q && (bs_tag_q == bsram_addr[19:1]));
    assign wr_edge  = we_dly_q && !bsram_we_n && !bsram_ce_n;

    // BSRAM tag is recovered from the issued address, not the live address
    assign bs_issued_tag = mem_addr_q[19:1] - BSRAM_BASE[19:1];

    // Next-state, request issue, latch fill and write-buffer capture
    always_comb begin
        state_d     = state_q;
        rom_lat_d   = rom_lat_q;
        rom_tag_d   = rom_tag_q;
        rom_vld_d   = rom_vld_q;
        bs_lat_d    = bs_lat_q;
        bs_tag_d    = bs_tag_q;
        bs_vld_d    = bs_vld_q;
        we_dly_d    = bsram_we_n;
        wr_pend_d   = wr_pend_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (wr_pend_q) begin
                    state_d     = BS_WR;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = BSRAM_BASE + {5'b0, wr_addr_q[19:1], 1'b0};
                    mem_be_d    = wr_addr_q[0] ? 2'b10 : 2'b01;
                    mem_wdata_d = {wr_data_q, wr_data_q};
                    wr_pend_d   = 1'b0;
                end else if (wr_edge) begin
                    // A write being captured this cycle goes out before any
                    // read miss that shows up alongside it.
                    state_d = IDLE;
                end else if (rom_miss) begin
                    state_d    = ROM_RD;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {1'b0, rom_addr[23:1], 1'b0};
                    mem_be_d   = 2'b11;
                end else if (bs_miss) begin
                    state_d    = BS_RD;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = BSRAM_BASE + {5'b0, bsram_addr[19:1], 1'b0};
                    mem_be_d   = 2'b11;
                end
            end
            ROM_RD: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    rom_lat_d = mem_rdata;
                    rom_tag_d = mem_addr_q[23:1];
                    rom_vld_d = 1'b1;
                end
            end
            BS_RD: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    bs_lat_d  = mem_rdata;
                    bs_tag_d  = bs_issued_tag;
                    bs_vld_d  = 1'b1;
                end
            end
            BS_WR: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Capture overrides an issue-clear in the same cycle; the merge sees
        // any latch fill completing this cycle so the latch stays coherent.
        if (wr_edge) begin
            wr_pend_d = 1'b1;
            wr_addr_d = bsram_addr;
            wr_data_d = bsram_d;
            if (bs_vld_d && (bs_tag_d == bsram_addr[19:1])) begin
                if (bsram_addr[0]) begin
                    bs_lat_d[15:8] = bsram_d;
                end else begin
                    bs_lat_d[7:0] = bsram_d;
                end
            end
        end
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            rom_lat_q   <= '0;
            rom_tag_q   <= '0;
            rom_vld_q   <= 1'b0;
            bs_lat_q    <= '0;
            bs_tag_q    <= '0;
            bs_vld_q    <= 1'b0;
            we_dly_q    <= 1'b1;
            wr_pend_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rom_lat_q   <= rom_lat_d;
            rom_tag_q   <= rom_tag_d;
            rom_vld_q   <= rom_vld_d;
            bs_lat_q    <= bs_lat_d;
            bs_tag_q    <= bs_tag_d;
            bs_vld_q    <= bs_vld_d;
            we_dly_q    <= we_dly_d;
            wr_pend_q   <= wr_pend_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Read data is served straight from the latches (zero-cycle hits)
    always_comb begin
        rom_q = rom_word ? rom_lat_q
                         : {8'h00, (rom_addr[0] ? rom_lat_q[15:8] : rom_lat_q[7:0])};
        bsram_q = bsram_addr[0] ? bs_lat_q[15:8] : bs_lat_q[7:0];
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cart_mem_responder.sv
// Directed bench for cart_mem_responder: expected memory requests are queued
// as stimulus is driven and checked when the responder raises mem_req.
module tb_cart_mem_responder;

    logic        MCLK = 1'b0;
    logic        RESET_N = 1'b1;
    logic [23:0] rom_addr = '0;
    logic        rom_ce_n = 1'b1;
    logic        rom_oe_n = 1'b1;
    logic        rom_word = 1'b1;
    logic [15:0] rom_q;
    logic [19:0] bsram_addr = '0;
    logic [7:0]  bsram_d = '0;
    logic        bsram_ce_n = 1'b1;
    logic        bsram_oe_n = 1'b1;
    logic        bsram_we_n = 1'b1;
    logic [7:0]  bsram_q;
    logic        mem_req;
    logic        mem_we;
    logic [24:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;

    typedef struct packed {
        logic        we;
        logic [24:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } req_t;

    req_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_issue = 0;
    logic req_prev = 1'b0;
    int   issue_mark;

    cart_mem_responder dut (
        .MCLK       (MCLK),
        .RESET_N    (RESET_N),
        .rom_addr   (rom_addr),
        .rom_ce_n   (rom_ce_n),
        .rom_oe_n   (rom_oe_n),
        .rom_word   (rom_word),
        .rom_q      (rom_q),
        .bsram_addr (bsram_addr),
        .bsram_d    (bsram_d),
        .bsram_ce_n (bsram_ce_n),
        .bsram_oe_n (bsram_oe_n),
        .bsram_we_n (bsram_we_n),
        .bsram_q    (bsram_q),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 MCLK = ~MCLK;

    // Count request rising edges, sampled mid-cycle
    always @(negedge MCLK) begin
        if (mem_req && !req_prev) n_issue++;
        req_prev = mem_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Act as the arbiter: wait for a request, check it against the
    // scoreboard, hold it for 'delay' cycles, then ack with 'rdata'.
    task automatic serve(input int delay, input logic [15:0] rdata);
        req_t e;
        int   t;
        t = 0;
        while (!mem_req && t < 50) begin
            tick();
            t++;
        end
        chk("req_seen", {31'b0, mem_req}, 32'd1);
        if (!mem_req) return;
        chk("sb_nonempty", {31'b0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk("req_we", {31'b0, mem_we}, {31'b0, e.we});
        chk("req_addr", {7'b0, mem_addr}, {7'b0, e.addr});
        chk("req_be", {30'b0, mem_be}, {30'b0, e.be});
        if (e.we) chk("req_wdata", {16'b0, mem_wdata}, {16'b0, e.wdata});
        for (int i = 0; i < delay; i++) begin
            tick();
            chk("hold_req", {31'b0, mem_req}, 32'd1);
            chk("hold_addr", {7'b0, mem_addr}, {7'b0, e.addr});
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        chk("req_drop", {31'b0, mem_req}, 32'd0);
    endtask

    initial begin
        // ---- reset values ----
        #2 RESET_N = 1'b0;
        #1;
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", {7'b0, mem_addr}, 32'd0);
        chk("rst_mem_be", {30'b0, mem_be}, 32'd0);
        chk("rst_mem_wdata", {16'b0, mem_wdata}, 32'd0);
        chk("rst_rom_q", {16'b0, rom_q}, 32'd0);
        chk("rst_bsram_q", {24'b0, bsram_q}, 32'd0);
        tick();
        tick();
        RESET_N = 1'b1;
        tick();

        // ---- ROM word read, ack 3 cycles after req, then byte hit ----
        rom_addr = 24'h000102; rom_word = 1'b1; rom_ce_n = 1'b0; rom_oe_n = 1'b0;
        exp_q.push_back('{we: 1'b0, addr: 25'h0000102, be: 2'b11, wdata: 16'h0});
        issue_mark = n_issue;
        serve(3, 16'hBEEF);
        chk("rom_word_q", {16'b0, rom_q}, 32'h0000BEEF);
        rom_addr = 24'h000103; rom_word = 1'b0;
        #1;
        chk("rom_byte_hit", {16'b0, rom_q}, 32'h000000BE);
        tick(); tick(); tick();
        chk("rom_hit_noreq", n_issue, issue_mark + 1);

        // ---- BSRAM read prime (0x1234), then write 0x5A to 0x00003 ----
        bsram_addr = 20'h00002; bsram_ce_n = 1'b0; bsram_oe_n = 1'b0;
        exp_q.push_back('{we: 1'b0, addr: 25'h1000002, be: 2'b11, wdata: 16'h0});
        serve(1, 16'h1234);
        chk("bs_rd_lo", {24'b0, bsram_q}, 32'h34);
        bsram_oe_n = 1'b1;
        bsram_addr = 20'h00003; bsram_d = 8'h5A; bsram_we_n = 1'b0;
        #1;
        chk("bs_rd_hi", {24'b0, bsram_q}, 32'h12);
        exp_q.push_back('{we: 1'b1, addr: 25'h1000002, be: 2'b10, wdata: 16'h5A5A});
        tick();
        chk("bs_merge", {24'b0, bsram_q}, 32'h5A);
        chk("wr_no_early_req", {31'b0, mem_req}, 32'd0);
        bsram_we_n = 1'b1;
        serve(1, 16'h0000);
        bsram_ce_n = 1'b1;

        // ---- ROM miss and write edge in the same cycle ----
        rom_addr = 24'h000200; rom_word = 1'b1;
        bsram_addr = 20'h00010; bsram_d = 8'h77; bsram_ce_n = 1'b0; bsram_we_n = 1'b0;
        exp_q.push_back('{we: 1'b1, addr: 25'h1000010, be: 2'b01, wdata: 16'h7777});
        exp_q.push_back('{we: 1'b0, addr: 25'h0000200, be: 2'b11, wdata: 16'h0});
        tick();
        chk("wr_holdoff", {31'b0, mem_req}, 32'd0);
        serve(1, 16'h0000);
        bsram_we_n = 1'b1; bsram_ce_n = 1'b1;
        tick();
        chk("b2b_gap_req", {31'b0, mem_req}, 32'd1);
        serve(0, 16'hCAFE);
        chk("rom_after_wr", {16'b0, rom_q}, 32'h0000CAFE);

        // ---- two write edges while a ROM read is outstanding ----
        rom_addr = 24'h000300;
        exp_q.push_back('{we: 1'b0, addr: 25'h0000300, be: 2'b11, wdata: 16'h0});
        issue_mark = n_issue;
        tick();
        chk("rom300_req", {31'b0, mem_req}, 32'd1);
        bsram_addr = 20'h00020; bsram_d = 8'h11; bsram_ce_n = 1'b0; bsram_we_n = 1'b0;
        tick();
        bsram_we_n = 1'b1;
        tick();
        bsram_addr = 20'h00041; bsram_d = 8'h22; bsram_we_n = 1'b0;
        tick();
        bsram_we_n = 1'b1; bsram_ce_n = 1'b1;
        exp_q.push_back('{we: 1'b1, addr: 25'h1000040, be: 2'b10, wdata: 16'h2222});
        serve(0, 16'hAAAA);
        serve(1, 16'h0000);
        tick(); tick(); tick(); tick();
        chk("one_write_only", n_issue, issue_mark + 2);
        chk("rom300_q", {16'b0, rom_q}, 32'h0000AAAA);

        // ---- live address moves during a ROM read ----
        rom_addr = 24'h000010;
        exp_q.push_back('{we: 1'b0, addr: 25'h0000010, be: 2'b11, wdata: 16'h0});
        tick();
        rom_addr = 24'h000020;
        serve(2, 16'h1111);
        chk("moved_q", {16'b0, rom_q}, 32'h00001111);
        exp_q.push_back('{we: 1'b0, addr: 25'h0000020, be: 2'b11, wdata: 16'h0});
        tick();
        chk("moved_reissue", {31'b0, mem_req}, 32'd1);
        serve(0, 16'h2222);
        chk("moved_q2", {16'b0, rom_q}, 32'h00002222);

        // ---- reset while a request is outstanding ----
        rom_addr = 24'h000400;
        tick();
        chk("pre_rst_req", {31'b0, mem_req}, 32'd1);
        #2 RESET_N = 1'b0;
        #1;
        chk("async_req_drop", {31'b0, mem_req}, 32'd0);
        chk("async_addr_clr", {7'b0, mem_addr}, 32'd0);
        chk("async_rom_q", {16'b0, rom_q}, 32'd0);
        tick();
        #2 RESET_N = 1'b1;
        exp_q.push_back('{we: 1'b0, addr: 25'h0000400, be: 2'b11, wdata: 16'h0});
        serve(0, 16'h4444);
        chk("post_rst_q", {16'b0, rom_q}, 32'h00004444);
        rom_ce_n = 1'b1; rom_oe_n = 1'b1;
        tick();
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
